// File: rtl/des128_pkg.sv
// Shared widths, defaults and FSM encoding for the DES128 Feistel cores.
package des128_pkg;
  localparam int BLOCK_W    = 128;
  localparam int HALF_W     = 64;
  localparam int DEF_ROUNDS = 16;
  localparam int DEF_KEY_W  = 96;
  localparam int DEF_IDX_W  = $clog2(DEF_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
  localparam logic [1:0] ST_ROUND = 2'(S_ROUND);
  localparam logic [1:0] ST_DONE  = 2'(S_DONE);

  typedef logic [DEF_IDX_W-1:0] key_idx_t;
endpackage

// File: rtl/des128_f_func.sv
// Round function: rotate (R ^ K.lo) by K[69:64], then add the
// replicated upper key word.
module des128_f_func
  import des128_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic [HALF_W-1:0] i_r,
  input  logic [KEY_W-1:0]  i_k,
  output logic [HALF_W-1:0] o_f
);
  logic [HALF_W-1:0]   w_x;
  logic [5:0]          w_sh;
  logic [2*HALF_W-1:0] w_dbl;
  logic [31:0]         w_hi;

  assign w_x   = i_r ^ i_k[HALF_W-1:0];
  assign w_sh  = i_k[69:64];
  // upper half of the doubled word is a left rotate
  assign w_dbl = {w_x, w_x} << w_sh;
  assign w_hi  = i_k[95:64];
  assign o_f   = w_dbl[2*HALF_W-1:HALF_W]
               + {w_hi, w_hi};
endmodule

// File: rtl/des128_decrypt_core.sv
// Iterative Feistel decryption core, one round per clock.
// DES128_DIR_SEL_EN adds a dir port selecting forward key order.
module des128_decrypt_core
  import des128_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int KEY_W  = DEF_KEY_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BLOCK_W-1:0]        in_block,
  output logic                      key_rd,
  output logic [$clog2(ROUNDS)-1:0] key_idx,
  input  logic [KEY_W-1:0]          round_key,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BLOCK_W-1:0]        out_block,
  output logic                      busy
`ifdef DES128_DIR_SEL_EN
  ,
  input  logic                      dir
`endif
);
  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(ROUNDS - 1);

  logic [1:0]        r_state;
  logic [HALF_W-1:0] r_l;
  logic [HALF_W-1:0] r_r;
  logic [IDX_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_last;
  logic              w_round;
  logic              w_enc_acc;
  logic              w_enc_run;
  logic [HALF_W-1:0] w_f;

`ifdef DES128_DIR_SEL_EN
  logic r_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= 1'b0;
    end else if (w_accept) begin
      r_dir <= dir;
    end
  end

  assign w_enc_acc = dir;
  assign w_enc_run = r_dir;
`else
  assign w_enc_acc = 1'b0;
  assign w_enc_run = 1'b0;
`endif

  assign in_ready  = rst_n & (r_state == ST_IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_round   = (r_state == ST_ROUND);
  assign w_last    = (r_cnt == LAST);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_block = out_valid ? {r_r, r_l}
                               : '0;

  des128_f_func #(
    .KEY_W (KEY_W)
  ) u_f (
    .i_r (r_r),
    .i_k (round_key),
    .o_f (w_f)
  );

  // request the key one cycle ahead of the round that uses it
  always_comb begin
    key_rd  = 1'b0;
    key_idx = '0;
    unique case (1'b1)
      w_accept: begin
        key_rd  = 1'b1;
        key_idx = w_enc_acc ? '0 : LAST;
      end
      (w_round && !w_last): begin
        key_rd  = 1'b1;
        key_idx = w_enc_run
                ? r_cnt + 1'b1
                : LAST - 1'b1 - r_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_l     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (w_accept) begin
            r_l     <= in_block[BLOCK_W-1:HALF_W];
            r_r     <= in_block[HALF_W-1:0];
            r_cnt   <= '0;
            r_state <= ST_ROUND;
          end
        end
        (r_state == ST_ROUND): begin
          r_l   <= r_r;
          r_r   <= r_l ^ w_f;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        (r_state == ST_DONE): begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des128_decrypt_core.sv
// Self-checking bench for des128_decrypt_core against a
// behavioural Feistel model; honours DES128_DIR_SEL_EN.
module tb_des128_decrypt_core;
  localparam int NR = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_block = '0;
  logic [95:0]  round_key = '0;
  logic         dir = 1'b0;
  logic         in_ready;
  logic         key_rd;
  logic [3:0]   key_idx;
  logic         out_valid;
  logic [127:0] out_block;
  logic         busy;

  logic [95:0]  keys [NR];
  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int kq[$];
  int kc[$];
  int ov_q[$];

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t tv [8];

  des128_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .key_rd    (key_rd),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
`ifdef DES128_DIR_SEL_EN
    ,
    .dir       (dir)
`endif
  );

  always #5 clk = ~clk;

  // key store: registered read, data one cycle after key_rd
  always @(posedge clk) begin
    if (key_rd) round_key <= keys[key_idx];
  end

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (key_rd) begin
      kq.push_back(int'(key_idx));
      kc.push_back(ncyc);
    end
    if (out_valid && out_ready) ov_q.push_back(ncyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] f_ref(
    input logic [63:0] r, input logic [95:0] k);
    logic [63:0] x;
    logic [63:0] rot;
    int s;
    x   = r ^ k[63:0];
    s   = int'(k[69:64]);
    rot = (x << s) | (x >> (64 - s));
    return rot + {k[95:64], k[95:64]};
  endfunction

  // enc=1: keys 0..NR-1, enc=0: keys NR-1..0
  function automatic logic [127:0] feistel(
    input logic [127:0] blk, input logic enc);
    logic [63:0] l;
    logic [63:0] r;
    logic [63:0] t;
    l = blk[127:64];
    r = blk[63:0];
    for (int i = 0; i < NR; i++) begin
      t = l ^ f_ref(r, enc ? keys[i] : keys[NR-1-i]);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [127:0] blk,
                           input logic d,
                           output logic [127:0] got,
                           output int lat);
    drv();
    in_valid = 1'b1;
    in_block = blk;
    dir = d;
    drv();
    in_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 60) break;
      lat++;
    end
    got = out_block;
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] got;
    int lat;
    int mism;

    // reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_rd", key_rd, 0);
    chk("rst_key_idx", key_idx, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // key order with key = index
    for (int i = 0; i < NR; i++) keys[i] = 96'(i);
    pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    ct = feistel(pt, 1'b1);
    kq.delete();
    kc.delete();
    run_block(ct, 1'b0, got, lat);
    chk("kord_latency", lat, NR);
    chk("kord_rd_cycles", kq.size(), NR);
    mism = 0;
    foreach (kq[j]) if (kq[j] != NR - 1 - j) mism++;
    chk("kord_seq_mism", mism, 0);
    if (kc.size() > 0)
      chk("kord_span", kc[kc.size()-1] - kc[0], NR - 1);
    chk("kord_plain", got, pt);

    // table-driven round trips with random keys
    for (int i = 0; i < NR; i++)
      keys[i] = {$urandom, $urandom, $urandom};
    tv[0].pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    for (int i = 1; i < 8; i++) tv[i].pt = rnd128();
    tv[7].pt = '0;
    for (int i = 0; i < 8; i++)
      tv[i].ct = feistel(tv[i].pt, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_block(tv[i].ct, 1'b0, got, lat);
      chk($sformatf("vec%0d_lat", i), lat, NR);
      chk($sformatf("vec%0d_pt", i), got, tv[i].pt);
    end

    // backpressure in DONE
    drv();
    out_ready = 1'b0;
    pt = rnd128();
    run_block(feistel(pt, 1'b1), 1'b0, got, lat);
    chk("bp_pt", got, pt);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_block", out_block, pt);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    drv();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_valid", out_valid, 0);

    // new data offered while busy is ignored
    pt = rnd128();
    kq.delete();
    drv();
    in_valid = 1'b1;
    in_block = feistel(pt, 1'b1);
    drv();
    for (int c = 0; c < 14; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_block = rnd128();
      drv();
    end
    in_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 40) break;
      lat++;
    end
    chk("ign_pt", out_block, pt);
    chk("ign_rd_cycles", kq.size(), NR);
    repeat (3) drv();
    @(negedge clk);
    chk("ign_idle", busy, 0);

    // throughput with in_valid held high
    ov_q.delete();
    pt = rnd128();
    drv();
    in_valid = 1'b1;
    in_block = feistel(pt, 1'b1);
    repeat (58) drv();
    in_valid = 1'b0;
    repeat (24) drv();
    chk("tp_count_ge3", ov_q.size() >= 3, 1);
    if (ov_q.size() >= 3) begin
      chk("tp_gap0", ov_q[1] - ov_q[0], NR + 2);
      chk("tp_gap1", ov_q[2] - ov_q[1], NR + 2);
    end

    // reset after round 7
    pt = rnd128();
    drv();
    in_valid = 1'b1;
    in_block = feistel(pt, 1'b1);
    drv();
    in_valid = 1'b0;
    repeat (7) drv();
    chk("mid_key_rd_pre", key_rd, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_key_rd", key_rd, 0);
    chk("mid_out_block", out_block, 0);
    chk("mid_busy", busy, 0);
    chk("mid_key_idx", key_idx, 0);
    kq.delete();
    drv();
    drv();
    rst_n = 1'b1;
    repeat (3) drv();
    chk("mid_no_key_rd", kq.size(), 0);
    @(negedge clk);
    chk("mid_in_ready", in_ready, 1);
    pt = rnd128();
    run_block(feistel(pt, 1'b1), 1'b0, got, lat);
    chk("mid_fresh_pt", got, pt);

`ifdef DES128_DIR_SEL_EN
    // forward key order, then decrypt back
    pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    kq.delete();
    run_block(pt, 1'b1, got, lat);
    chk("dir_enc", got, feistel(pt, 1'b1));
    chk("dir_rd_cycles", kq.size(), NR);
    mism = 0;
    foreach (kq[j]) if (kq[j] != j) mism++;
    chk("dir_seq_mism", mism, 0);
    ct = got;
    run_block(ct, 1'b0, got, lat);
    chk("dir_round_trip", got, pt);
`endif

    drv();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
